w_mem_access_sequencer: RTL and testbench

//  Sequences the weight-memory SRAM wrapper. Loader writes are accepted only while idle. On start, issues a
//  run of reads (CNN 32-bit words or FC 128-bit words) over [base, base+num_words) repeated num_passes times,
//  and streams the words to the PE array through a valid/ready credit FIFO. The memory has a fixed 1-cycle

---
 rtl/w_mem_access_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_w_mem_access_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/w_mem_access_sequencer.sv
// Weight-memory access sequencer: loader writes while idle, then repeated linear read passes
// streamed to the PE array through a small credit-controlled FIFO that absorbs the read latency.
module w_mem_access_sequencer #(
    parameter int ADDR_W     = 12,
    parameter int CNN_W      = 32,
    parameter int FC_W       = 128,
    parameter int FIFO_DEPTH = 2,
    parameter int MODE_CNN   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [2:0]        cfg_mode,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W-1:0] cfg_num_words,
    input  logic [7:0]        cfg_num_passes,
    output logic              busy,
    output logic              done,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic              ld_fc,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [CNN_W-1:0]  ld_data,
    output logic [2:0]        mem_mode,
    output logic              mem_rd_enable,
    output logic [ADDR_W-1:0] mem_rd_addr_cnn,
    output logic [ADDR_W-1:0] mem_rd_addr_fc,
    output logic              mem_wr_enable_cnn,
    output logic              mem_wr_enable_fc,
    output logic [ADDR_W-1:0] mem_wr_addr_cnn,
    output logic [ADDR_W-1:0] mem_wr_addr_fc,
    output logic [CNN_W-1:0]  mem_wr_data_cnn,
    output logic [CNN_W-1:0]  mem_wr_data_fc,
    input  logic [CNN_W-1:0]  mem_rd_data,
    input  logic [FC_W-1:0]   mem_rd_data_fc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FC_W-1:0]   out_data,
    output logic              out_last
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state, state_next;

    logic [2:0]        mode_q;
    logic [ADDR_W-1:0] base_q, num_q, idx_q;
    logic [7:0]        passes_q, pass_q;
    logic              zero_done;
    logic              rd_vld_p1, rd_last_p1;

    logic [FC_W-1:0]   fifo_data [FIFO_DEPTH];
    logic              fifo_last [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;

    logic              pop, push, rd_issue, rd_last, credit_ok, drained;
    logic [OCC_W-1:0]  occupancy;
    logic [FC_W-1:0]   rd_word;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Credits count both stored words and the one read whose data is still on the memory bus.
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign push      = rd_vld_p1 & ~abort;
    assign occupancy = OCC_W'(count) + OCC_W'(rd_vld_p1) - OCC_W'(pop);
    assign credit_ok = (occupancy < OCC_W'(FIFO_DEPTH));
    assign rd_last   = (idx_q == num_q - ADDR_W'(1)) && (pass_q == passes_q - 8'd1);
    assign drained   = (count == '0) && !rd_vld_p1;
    assign rd_word   = (mode_q == 3'(MODE_CNN)) ? FC_W'(mem_rd_data) : mem_rd_data_fc;

    assign mem_rd_addr_cnn = base_q + idx_q;
    assign mem_rd_addr_fc  = base_q + idx_q;
    assign mem_wr_addr_cnn = ld_addr;
    assign mem_wr_addr_fc  = ld_addr;
    assign mem_wr_data_cnn = ld_data;
    assign mem_wr_data_fc  = ld_data;
    assign out_data        = fifo_data[rd_ptr];
    assign out_last        = out_valid & fifo_last[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start && cfg_num_words != '0) state_next = RUN;
            RUN:     if (abort) state_next = IDLE;
                     else if (rd_issue && rd_last) state_next = DRAIN;
            DRAIN:   if (abort || drained) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy              = (state == RUN) || (state == DRAIN);
        ld_ready          = (state == IDLE);
        done              = zero_done | ((state == DRAIN) && drained && !abort);
        rd_issue          = (state == RUN) && credit_ok && !abort;
        mem_rd_enable     = rd_issue;
        mem_wr_enable_cnn = ld_ready & ld_valid & ~ld_fc;
        mem_wr_enable_fc  = ld_ready & ld_valid & ld_fc;
        mem_mode          = (state == IDLE) ? cfg_mode : mode_q;
    end

    // Stage p0: latched run configuration and read index/pass counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q    <= '0;
            base_q    <= '0;
            num_q     <= '0;
            passes_q  <= '0;
            idx_q     <= '0;
            pass_q    <= '0;
            zero_done <= 1'b0;
        end else begin
            zero_done <= (state == IDLE) && start && (cfg_num_words == '0);
            if (state == IDLE && start) begin
                mode_q   <= cfg_mode;
                base_q   <= cfg_base;
                num_q    <= cfg_num_words;
                passes_q <= (cfg_num_passes == 8'd0) ? 8'd1 : cfg_num_passes;
                idx_q    <= '0;
                pass_q   <= '0;
            end else if (rd_issue) begin
                if (idx_q == num_q - ADDR_W'(1)) begin
                    idx_q  <= '0;
                    pass_q <= pass_q + 8'd1;
                end else begin
                    idx_q <= idx_q + ADDR_W'(1);
                end
            end
        end
    end

    // Stage p1: read in flight; data returns from the memory this cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_vld_p1  <= 1'b0;
            rd_last_p1 <= 1'b0;
        end else begin
            rd_vld_p1  <= rd_issue;
            rd_last_p1 <= rd_issue & rd_last;
        end
    end

    // Stage p2: output FIFO; abort discards stored words and the in-flight return
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (abort && busy) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= rd_word;
            fifo_last[wr_ptr] <= rd_last_p1;
        end
    end

endmodule

// File: tb/tb_w_mem_access_sequencer.sv
// Bench for w_mem_access_sequencer: behavioural SRAM plus a loop-based model of the expected read/stream
// sequence, exercised by directed and randomized runs.
module tb_w_mem_access_sequencer;

    localparam int ADDR_W = 12;
    localparam int CNN_W  = 32;
    localparam int FC_W   = 128;
    localparam int DEPTH  = 2;
    localparam logic [2:0] MODE_CNN = 3'd1;
    localparam logic [2:0] MODE_FC  = 3'd2;

    logic              clk = 1'b0;
    logic              reset, start, abort;
    logic [2:0]        cfg_mode;
    logic [ADDR_W-1:0] cfg_base, cfg_num_words;
    logic [7:0]        cfg_num_passes;
    logic              busy, done, ld_valid, ld_ready, ld_fc;
    logic [ADDR_W-1:0] ld_addr;
    logic [CNN_W-1:0]  ld_data;
    logic [2:0]        mem_mode;
    logic              mem_rd_enable, mem_wr_enable_cnn, mem_wr_enable_fc;
    logic [ADDR_W-1:0] mem_rd_addr_cnn, mem_rd_addr_fc, mem_wr_addr_cnn, mem_wr_addr_fc;
    logic [CNN_W-1:0]  mem_wr_data_cnn, mem_wr_data_fc, mem_rd_data;
    logic [FC_W-1:0]   mem_rd_data_fc, out_data;
    logic              out_valid, out_ready, out_last;

    int n_checks = 0;
    int n_fail   = 0;

    w_mem_access_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .cfg_mode(cfg_mode), .cfg_base(cfg_base), .cfg_num_words(cfg_num_words),
        .cfg_num_passes(cfg_num_passes), .busy(busy), .done(done),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_fc(ld_fc), .ld_addr(ld_addr), .ld_data(ld_data),
        .mem_mode(mem_mode), .mem_rd_enable(mem_rd_enable),
        .mem_rd_addr_cnn(mem_rd_addr_cnn), .mem_rd_addr_fc(mem_rd_addr_fc),
        .mem_wr_enable_cnn(mem_wr_enable_cnn), .mem_wr_enable_fc(mem_wr_enable_fc),
        .mem_wr_addr_cnn(mem_wr_addr_cnn), .mem_wr_addr_fc(mem_wr_addr_fc),
        .mem_wr_data_cnn(mem_wr_data_cnn), .mem_wr_data_fc(mem_wr_data_fc),
        .mem_rd_data(mem_rd_data), .mem_rd_data_fc(mem_rd_data_fc),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: CNN words default to a hash of the address until written; FC words are a pure function.
    logic [CNN_W-1:0] wr_mem [4096];
    bit               written [4096];

    function automatic logic [31:0] cnn_hash(input logic [11:0] a);
        return {a ^ 12'h5A3, 4'h9, ~a, 4'h6};
    endfunction

    function automatic logic [127:0] fc_word(input logic [11:0] a);
        return {cnn_hash(a), 32'hF00D0000 | {20'h0, a}, ~cnn_hash(a), a, a, 8'hC3};
    endfunction

    function automatic logic [31:0] cnn_read(input logic [11:0] a);
        return written[a] ? wr_mem[a] : cnn_hash(a);
    endfunction

    always @(posedge clk) begin
        if (mem_wr_enable_cnn) begin
            wr_mem[mem_wr_addr_cnn]  <= mem_wr_data_cnn;
            written[mem_wr_addr_cnn] <= 1'b1;
        end
        mem_rd_data    <= mem_rd_enable ? cnn_read(mem_rd_addr_cnn) : $urandom();
        mem_rd_data_fc <= mem_rd_enable ? fc_word(mem_rd_addr_fc)
                                        : {$urandom(), $urandom(), $urandom(), $urandom()};
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 1'b0; abort = 1'b0; ld_valid = 1'b0; ld_fc = 1'b0;
        ld_addr = '0; ld_data = '0; out_ready = 1'b1;
    endtask

    // One complete run starting at the current cycle (entered and left at posedge+1).
    // rmode: 0 = always ready, 1 = random ready, 2 = ready low for 5 cycles mid-run.
    task automatic run(input string name, input logic [2:0] mode, input logic [11:0] base,
                       input logic [11:0] num, input logic [7:0] passes, input int rmode,
                       input bit ld_start, input logic [11:0] lda, input logic [31:0] ldd);
        logic [11:0]  got_addr[$], exp_addr[$];
        logic [127:0] got_word[$], exp_word[$];
        bit           got_last[$], exp_last[$];
        int           rd_cyc[$], pop_cyc[$], done_cyc[$];
        int           issued, popped, max_out, port_bad, eff, stop_k;
        issued = 0; popped = 0; max_out = 0; port_bad = 0; stop_k = 600;
        for (int k = 0; k < stop_k; k++) begin
            if (k == 0) begin
                cfg_mode = mode; cfg_base = base; cfg_num_words = num; cfg_num_passes = passes;
                start = 1'b1; ld_valid = ld_start; ld_fc = 1'b0; ld_addr = lda; ld_data = ldd;
            end else begin
                // config and start are scrambled while busy and must have no effect
                cfg_mode = 3'($urandom()); cfg_base = 12'($urandom());
                cfg_num_words = 12'($urandom_range(1, 9)); cfg_num_passes = 8'($urandom());
                start = (k == 2);
                ld_valid = (k == 1); ld_fc = 1'($urandom()); ld_addr = 12'($urandom()); ld_data = $urandom();
            end
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 99) < 60);
                default: out_ready = !(k >= 4 && k < 9);
            endcase
            @(negedge clk);
            if (k == 0 && ld_start) begin
                chk({name, "_ldstart_wr"}, {mem_wr_enable_cnn, mem_wr_enable_fc}, 2'b10);
                chk({name, "_ldstart_data"}, {mem_wr_addr_cnn, mem_wr_data_cnn}, {lda, ldd});
            end
            if (k == 1) begin
                chk({name, "_run_busy"}, busy, 1'b1);
                chk({name, "_run_ldready"}, ld_ready, 1'b0);
                chk({name, "_run_nowrite"}, {mem_wr_enable_cnn, mem_wr_enable_fc}, 2'b00);
                chk({name, "_run_mode"}, mem_mode, mode);
            end
            if (mem_rd_enable) begin
                got_addr.push_back(mem_rd_addr_cnn);
                rd_cyc.push_back(k);
                issued++;
                if (mem_rd_addr_fc !== mem_rd_addr_cnn) port_bad++;
            end
            if (out_valid && out_ready) begin
                got_word.push_back(out_data);
                got_last.push_back(out_last);
                pop_cyc.push_back(k);
                popped++;
            end
            if (issued - popped > max_out) max_out = issued - popped;
            if (done) begin
                done_cyc.push_back(k);
                if (stop_k == 600) stop_k = k + 3;
            end
            step();
        end
        idle_inputs();
        cfg_mode = mode;
        @(negedge clk);
        chk({name, "_end_idle"}, {busy, ld_ready, out_valid}, 3'b010);

        // Reference: passes x words over a wrapping address window
        eff = (passes == 8'd0) ? 1 : int'(passes);
        for (int p = 0; p < eff; p++)
            for (int i = 0; i < int'(num); i++) begin
                logic [11:0] a;
                a = base + 12'(i);
                exp_addr.push_back(a);
                exp_word.push_back((mode == MODE_CNN) ? {96'h0, cnn_read(a)} : fc_word(a));
                exp_last.push_back((p == eff - 1) && (i == int'(num) - 1));
            end

        chk({name, "_done_count"}, done_cyc.size(), 1);
        chk({name, "_nreads"}, got_addr.size(), exp_addr.size());
        chk({name, "_nwords"}, got_word.size(), exp_word.size());
        for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++)
            chk($sformatf("%s_addr%0d", name, i), got_addr[i], exp_addr[i]);
        for (int i = 0; i < got_word.size() && i < exp_word.size(); i++) begin
            chk($sformatf("%s_word%0d", name, i), got_word[i], exp_word[i]);
            chk($sformatf("%s_last%0d", name, i), got_last[i], exp_last[i]);
        end
        chk({name, "_port_addr_equal"}, port_bad, 0);
        chk({name, "_credit_limit"}, (max_out <= DEPTH), 1'b1);
        if (rd_cyc.size() > 0) chk({name, "_first_read_cyc"}, rd_cyc[0], 1);
        if (done_cyc.size() > 0 && pop_cyc.size() > 0)
            chk({name, "_done_after_last_pop"}, done_cyc[0], pop_cyc[pop_cyc.size() - 1] + 1);
        if (rmode == 0 && done_cyc.size() > 0 && pop_cyc.size() > 0) begin
            chk({name, "_first_out_cyc"}, pop_cyc[0], 3);
            chk({name, "_done_cyc"}, done_cyc[0], exp_word.size() + 3);
        end
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nrd, ndone, nval;
        reset = 1'b0;
        idle_inputs();
        cfg_mode = 3'd0; cfg_base = '0; cfg_num_words = '0; cfg_num_passes = '0;

        #3;
        chk("rst_busy_done", {busy, done}, 2'b00);
        chk("rst_stream", {out_valid, out_last}, 2'b00);
        chk("rst_mem_strobes", {mem_rd_enable, mem_wr_enable_cnn, mem_wr_enable_fc}, 3'b000);
        chk("rst_ldready_mode", {ld_ready, mem_mode}, {1'b1, 3'd0});
        step(); step();
        reset = 1'b1;
        step();

        // Loader writes in IDLE on each port
        ld_valid = 1'b1; ld_fc = 1'b0; ld_addr = 12'h3A5; ld_data = 32'hCAFE_1234;
        @(negedge clk);
        chk("ld_cnn_strobe", {mem_wr_enable_cnn, mem_wr_enable_fc}, 2'b10);
        chk("ld_cnn_addr_data", {mem_wr_addr_cnn, mem_wr_data_cnn}, {12'h3A5, 32'hCAFE_1234});
        step();
        ld_fc = 1'b1; ld_addr = 12'h07E; ld_data = 32'h0BAD_F00D;
        @(negedge clk);
        chk("ld_fc_strobe", {mem_wr_enable_cnn, mem_wr_enable_fc}, 2'b01);
        chk("ld_fc_addr_data", {mem_wr_addr_fc, mem_wr_data_fc}, {12'h07E, 32'h0BAD_F00D});
        step();
        idle_inputs();

        run("t1_cnn", MODE_CNN, 12'h010, 12'd4, 8'd1, 0, 1'b0, '0, '0);
        run("t2_fc_wrap", MODE_FC, 12'hFFE, 12'd3, 8'd2, 0, 1'b0, '0, '0);
        run("t3_backpressure", MODE_CNN, 12'h040, 12'd10, 8'd1, 2, 1'b0, '0, '0);
        run("t5_ld_start", MODE_CNN, 12'h3A3, 12'd4, 8'd1, 1, 1'b1, 12'h3A4, 32'h5EED_0001);

        // Zero-length run: done the next cycle, no reads
        cfg_mode = MODE_CNN; cfg_base = 12'h123; cfg_num_words = '0; cfg_num_passes = 8'd1; start = 1'b1;
        @(negedge clk);
        chk("zero_done_T0", {done, mem_rd_enable}, 2'b00);
        step();
        start = 1'b0;
        @(negedge clk);
        chk("zero_done_T1", {done, busy, mem_rd_enable}, 3'b100);
        nrd = 0; ndone = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            @(negedge clk);
            nrd += int'(mem_rd_enable);
            ndone += int'(done);
        end
        chk("zero_no_reads_after", {nrd[7:0], ndone[7:0]}, 16'h0000);
        step();

        // Abort in DRAIN with one stored word and one read in flight
        cfg_mode = MODE_CNN; cfg_base = 12'h200; cfg_num_words = 12'd2; cfg_num_passes = 8'd1;
        out_ready = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        abort = 1'b1;
        @(negedge clk);
        chk("abort_pre_state", {busy, out_valid, done}, 3'b110);
        step();
        abort = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("abort_next_cycle", {busy, out_valid, done, ld_ready}, 4'b0001);
        nval = 0; ndone = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            @(negedge clk);
            nval += int'(out_valid);
            ndone += int'(done);
        end
        chk("abort_flushed", {nval[7:0], ndone[7:0]}, 16'h0000);
        step();

        run("t6_after_abort", MODE_FC, 12'h200, 12'd3, 8'd1, 0, 1'b0, '0, '0);

        // Asynchronous reset in the middle of a run
        cfg_mode = MODE_FC; cfg_base = 12'h777; cfg_num_words = 12'd6; cfg_num_passes = 8'd2; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        #2;
        reset = 1'b0; cfg_mode = 3'd0;
        #1;
        chk("midrst_busy_done", {busy, done}, 2'b00);
        chk("midrst_stream", {out_valid, out_last}, 2'b00);
        chk("midrst_strobes", {mem_rd_enable, mem_wr_enable_cnn, mem_wr_enable_fc}, 3'b000);
        chk("midrst_ldready_mode", {ld_ready, mem_mode}, {1'b1, 3'd0});
        step();
        reset = 1'b1;
        step();

        for (int r = 0; r < 6; r++) begin
            logic [2:0] m;
            m = ($urandom_range(0, 1) == 1) ? MODE_CNN : MODE_FC;
            run($sformatf("rnd%0d", r), m, 12'($urandom()), 12'($urandom_range(1, 6)),
                8'($urandom_range(0, 3)), 1, 1'b0, '0, '0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
